ppd_frame_packer: RTL and testbench

PPD_FRAME_PACKER -- requirements
Module: ppd_frame_packer

---
 rtl/ppd_frame_packer.sv | 160 ++++++++++++++++
 tb/tb_ppd_frame_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppd_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : ppd_frame_packer
// Purpose  : Packs a push-only 48-bit sample stream into fixed-length packets
//            for a downstream host FIFO. Each packet is a header word
//            {SYNC, seq, PKT_LEN} followed by PKT_LEN payload words. When the
//            sample stream stalls mid-packet for TIMEOUT cycles, the packet
//            is finished with zero pad words. An 8-deep FIFO absorbs input
//            while the header is written or the downstream FIFO is full.
// Ports    : clk_clk      - clock, rising edge
//            reset_reset  - asynchronous active-high reset
//            in_wdata     - input sample word
//            in_wrreq     - input sample strobe (no backpressure)
//            enable       - accept samples when high
//            out_wdata    - word to downstream FIFO
//            out_wrreq    - downstream write strobe (combinational)
//            out_wrfull   - downstream FIFO full
//            pkt_count    - completed packets (wraps)
//            drop_count   - samples lost to internal overflow (wraps)
//            busy         - high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module ppd_frame_packer #(
  parameter int          PKT_LEN = 128,
  parameter int          TIMEOUT = 1024,
  parameter logic [15:0] SYNC    = 16'hA5C3
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [47:0] in_wdata,
  input  logic        in_wrreq,
  input  logic        enable,
  output logic [47:0] out_wdata,
  output logic        out_wrreq,
  input  logic        out_wrfull,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic        busy
);

  localparam logic [15:0] c_PKT_LEN = 16'(PKT_LEN);
  // Idle count value at which the next empty cycle completes the timeout.
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_PAD     = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [47:0] r_mem [8];
  logic [2:0]  r_wptr, r_rptr;
  logic [3:0]  r_cnt;
  logic [15:0] r_rem, w_rem_nxt;
  logic [15:0] r_idle, w_idle_nxt;
  logic [15:0] r_seq, w_seq_nxt;
  logic [31:0] r_pkt, w_pkt_nxt;
  logic [31:0] r_drop;

  logic       w_empty, w_full, w_push, w_drop, w_pop;
  logic [3:0] w_cnt_nxt;

  // Full/empty use pre-edge occupancy, so a push into a full FIFO is
  // dropped even when a pop happens on the same edge.
  assign w_empty   = (r_cnt == 4'd0);
  assign w_full    = r_cnt[3];
  assign w_push    = in_wrreq & enable & ~w_full;
  assign w_drop    = in_wrreq & enable & w_full;
  assign w_pop     = (r_state == S_PAYLOAD) & ~out_wrfull & ~w_empty;
  assign w_cnt_nxt = r_cnt + {3'b000, w_push} - {3'b000, w_pop};

  assign out_wrreq = ~out_wrfull & ((r_state == S_HEADER) | (r_state == S_PAD) |
                                    ((r_state == S_PAYLOAD) & ~w_empty));
  assign busy       = (r_state != S_IDLE);
  assign pkt_count  = r_pkt;
  assign drop_count = r_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_idle_nxt  = 16'd0;
    w_seq_nxt   = r_seq;
    w_pkt_nxt   = r_pkt;
    out_wdata   = 48'h0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !out_wrfull) w_state_nxt = S_HEADER;
      end
      S_HEADER: begin
        out_wdata = {SYNC, r_seq, c_PKT_LEN};
        if (out_wrreq) begin
          w_state_nxt = S_PAYLOAD;
          w_rem_nxt   = c_PKT_LEN;
        end
      end
      S_PAYLOAD: begin
        out_wdata = r_mem[r_rptr];
        if (out_wrfull) begin
          w_idle_nxt = r_idle;
        end else if (!w_pop) begin
          // FIFO empty this cycle: count it, and switch to padding once
          // TIMEOUT consecutive empty cycles have elapsed. A sample pushed
          // on that same edge simply waits in the FIFO for the next packet.
          if (r_idle == c_TO_LAST) begin
            w_state_nxt = S_PAD;
          end else begin
            w_idle_nxt = r_idle + 16'd1;
          end
        end
      end
      default: begin
        out_wdata = 48'h0;
      end
    endcase

    if (out_wrreq && ((r_state == S_PAYLOAD) || (r_state == S_PAD))) begin
      w_rem_nxt = r_rem - 16'd1;
      if (r_rem == 16'd1) begin
        w_seq_nxt = r_seq + 16'd1;
        w_pkt_nxt = r_pkt + 32'd1;
        // Passing through IDLE takes no cycle when data is already waiting,
        // so back-to-back packets cost only the header word.
        w_state_nxt = (w_cnt_nxt != 4'd0) ? S_HEADER : S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state <= S_IDLE;
      r_wptr  <= 3'd0;
      r_rptr  <= 3'd0;
      r_cnt   <= 4'd0;
      r_rem   <= 16'd0;
      r_idle  <= 16'd0;
      r_seq   <= 16'd0;
      r_pkt   <= 32'd0;
      r_drop  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_idle  <= w_idle_nxt;
      r_seq   <= w_seq_nxt;
      r_pkt   <= w_pkt_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_push) r_wptr <= r_wptr + 3'd1;
      if (w_pop)  r_rptr <= r_rptr + 3'd1;
      if (w_drop) r_drop <= r_drop + 32'd1;
    end
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk_clk) begin
    if (w_push) r_mem[r_wptr] <= in_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_ppd_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppd_frame_packer
// Purpose  : Self-checking bench for ppd_frame_packer (PKT_LEN=4, TIMEOUT=8).
//            Stimulus pushes expected output words into a queue; a monitor
//            compares every downstream write against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppd_frame_packer;

  localparam int C_PKT_LEN = 4;
  localparam int C_TIMEOUT = 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [47:0] in_wdata = 48'h0;
  logic        in_wrreq = 1'b0;
  logic        enable = 1'b1;
  logic [47:0] out_wdata;
  logic        out_wrreq;
  logic        out_wrfull = 1'b0;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
  logic        busy;

  ppd_frame_packer #(
    .PKT_LEN(C_PKT_LEN),
    .TIMEOUT(C_TIMEOUT),
    .SYNC   (16'hA5C3)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .in_wdata   (in_wdata),
    .in_wrreq   (in_wrreq),
    .enable     (enable),
    .out_wdata  (out_wdata),
    .out_wrreq  (out_wrreq),
    .out_wrfull (out_wrfull),
    .pkt_count  (pkt_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [47:0] exp_q [$];
  int          wr_cyc [$];

  always @(posedge clk_clk) cyc <= cyc + 1;

  // Monitor: a write takes effect on the next rising edge, so the cycle
  // recorded here is one less than the edge number of the write.
  always @(negedge clk_clk) begin
    if (!reset_reset && out_wrreq) begin
      logic [47:0] e;
      wr_cyc.push_back(cyc);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %h, required no write", out_wdata);
      end else begin
        e = exp_q.pop_front();
        if (out_wdata !== e) begin
          n_fail++;
          $display("FAIL out_word: got %h, required %h", out_wdata, e);
        end
      end
    end
  end

  function automatic logic [47:0] hdr(input logic [15:0] seq);
    return {16'hA5C3, seq, 16'(C_PKT_LEN)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [47:0] d);
    in_wdata = d;
    in_wrreq = 1'b1;
    @(posedge clk_clk); #1;
    in_wrreq = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_clk); #1;
    end
  endtask

  task automatic do_reset(input bit chk);
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    if (chk) begin
      check("rst_out_wrreq", 64'(out_wrreq), 64'd0);
      check("rst_out_wdata", 64'(out_wdata), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_pkt_count", 64'(pkt_count), 64'd0);
      check("rst_drop_count", 64'(drop_count), 64'd0);
    end
    reset_reset = 1'b0;
    exp_q.delete();
    wr_cyc.delete();
    idle(1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 300 && (exp_q.size() != 0 || busy)) begin
      @(posedge clk_clk); #1;
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words pending busy=%b, required 0 pending and idle",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int n;

    // Four samples spaced two cycles apart, one full packet.
    do_reset(1'b1);
    exp_q.push_back(hdr(16'h0000));
    for (int i = 1; i <= 4; i++) exp_q.push_back(48'(i));
    pc = cyc;
    push(48'd1); idle(1);
    push(48'd2); idle(1);
    push(48'd3); idle(1);
    push(48'd4);
    wait_done("basic");
    check("basic_pkt_count", 64'(pkt_count), 64'd1);
    check("basic_busy", 64'(busy), 64'd0);
    check("latency_header", 64'(wr_cyc[0] - pc), 64'd2);
    check("latency_sample", 64'(wr_cyc[1] - pc), 64'd3);

    // Two samples then silence: timeout padding completes the packet.
    do_reset(1'b0);
    exp_q.push_back(hdr(16'h0000));
    exp_q.push_back(48'hAA);
    exp_q.push_back(48'hBB);
    exp_q.push_back(48'h0);
    exp_q.push_back(48'h0);
    push(48'hAA);
    push(48'hBB);
    wait_done("pad");
    check("pad_pkt_count", 64'(pkt_count), 64'd1);
    check("pad_idle_gap", 64'(wr_cyc[3] - wr_cyc[2]), 64'(C_TIMEOUT + 1));
    exp_q.push_back(hdr(16'h0001));
    exp_q.push_back(48'hCC);
    for (int i = 0; i < 3; i++) exp_q.push_back(48'h0);
    push(48'hCC);
    wait_done("pad2");
    check("pad2_pkt_count", 64'(pkt_count), 64'd2);

    // Downstream full while 10 samples arrive back to back.
    do_reset(1'b0);
    out_wrfull = 1'b1;
    for (int i = 1; i <= 10; i++) push(48'(i));
    idle(2);
    check("full_drop_count", 64'(drop_count), 64'd2);
    check("full_writes", 64'(wr_cyc.size()), 64'd0);
    check("full_busy", 64'(busy), 64'd0);
    exp_q.push_back(hdr(16'h0000));
    for (int i = 1; i <= 4; i++) exp_q.push_back(48'(i));
    exp_q.push_back(hdr(16'h0001));
    for (int i = 5; i <= 8; i++) exp_q.push_back(48'(i));
    out_wrfull = 1'b0;
    wait_done("full");
    check("full_pkt_count", 64'(pkt_count), 64'd2);
    check("full_drop_final", 64'(drop_count), 64'd2);

    // Strobes ignored while disabled.
    do_reset(1'b0);
    enable = 1'b0;
    for (int i = 1; i <= 5; i++) push(48'(i + 100));
    idle(4);
    check("dis_drop_count", 64'(drop_count), 64'd0);
    check("dis_busy", 64'(busy), 64'd0);
    check("dis_writes", 64'(wr_cyc.size()), 64'd0);
    enable = 1'b1;

    // Reset after header plus two payload words abandons the packet.
    do_reset(1'b0);
    exp_q.push_back(hdr(16'h0000));
    exp_q.push_back(48'd1);
    exp_q.push_back(48'd2);
    push(48'd1); push(48'd2); push(48'd3);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk_clk); #1;
      n++;
    end
    check("mid_reset_reached", 64'(exp_q.size()), 64'd0);
    do_reset(1'b1);
    exp_q.push_back(hdr(16'h0000));
    exp_q.push_back(48'd9);
    for (int i = 0; i < 3; i++) exp_q.push_back(48'h0);
    push(48'd9);
    idle(4);
    check("mid_pkt_before", 64'(pkt_count), 64'd0);
    wait_done("mid");
    check("mid_pkt_after", 64'(pkt_count), 64'd1);

    // Sequence number wrap from 0xFFFF.
    do_reset(1'b0);
    force dut.r_seq = 16'hFFFF;
    @(posedge clk_clk); #1;
    release dut.r_seq;
    exp_q.push_back(hdr(16'hFFFF));
    for (int i = 1; i <= 4; i++) exp_q.push_back(48'(i));
    exp_q.push_back(hdr(16'h0000));
    exp_q.push_back(48'd5);
    for (int i = 0; i < 3; i++) exp_q.push_back(48'h0);
    for (int i = 1; i <= 5; i++) push(48'(i));
    wait_done("wrap");
    check("wrap_pkt_count", 64'(pkt_count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
